conv_mem_host: RTL and testbench
================================

# conv_mem_host

Memory-side responder for the CONV layer engine. It holds the 64x64 input image and the two layer result memories: L0 for convolution+ReLU (64x64) and L1 for max-pool (32x32). It answers the engine's image-read, layer-write and layer-read ports and runs the load → ready → busy → done handshake. It sits between the system load/dump stream and the CONV engine, taking the place of the bench-side memory model in the integrated design.

## Interface
- IMG_AW, 12: image/L0 address width (4096 words)
- L1_AW, 10: L1 address width (1024 words)
- DW, 20: data word width (signed Q4.16)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- load_valid  in  1  image load beat valid
- load_data  in  20  image pixel, raster order
- load_ready  out  1  load beat accepted when load_valid & load_ready
- ready  out  1  image loaded; request engine start
- busy  in  1  engine busy
- iaddr  in  12  engine image read address
- idata  out  20  image word at iaddr
- cwr  in  1  engine layer write strobe
- caddr_wr  in  12  layer write address
- cdata_wr  in  20  layer write data
- crd  in  1  engine layer read enable
- caddr_rd  in  12  layer read address
- cdata_rd  out  20  layer read data
- csel  in  3  bank select: 3'b001 = L0, 3'b011 = L1, others = none
- done  out  1  engine finished; high in DONE
- err  out  1  sticky protocol error
- dump_valid  out  1  L1 dump beat valid (CONV_HOST_DUMP_EN)
- dump_data  out  20  L1 word (CONV_HOST_DUMP_EN)
- dump_ready  in  1  dump beat consumed (CONV_HOST_DUMP_EN)

## Operation
- FSM states: IDLE, LOAD, READY, RUN, DUMP, DONE.
- IDLE/LOAD: load_ready=1. A 12-bit counter addresses img and increments per accepted beat. The first beat moves IDLE→LOAD. When beat 4095 is accepted, the FSM goes to READY and the counter wraps to 0.
- READY: ready=1. When busy is sampled 1, the FSM goes to RUN and ready drops.
- RUN: when busy is sampled 0, the FSM goes to DUMP if CONV_HOST_DUMP_EN is defined, else to DONE.
- DONE: done=1. An accepted load beat restarts LOAD at address 0; that beat is written to img[0].
- Image read: idata = img[iaddr], combinational.
- Layer write: at the clk edge with cwr=1:
  - csel=001 writes L0[caddr_wr].
  - csel=011 writes L1[caddr_wr[9:0]].
  - Other csel values are ignored.
- Layer read: cdata_rd is combinational.
  - crd=1 & csel=001 → L0[caddr_rd].
  - crd=1 & csel=011 → L1[caddr_rd[9:0]].
  - Otherwise cdata_rd = 0.
- err set conditions (cleared only by reset):
  - cwr or crd while state is not RUN.
  - L1 access with address bit 11 or bit 10 set.
  - cwr with an unmapped csel.
  - load_valid while in READY or RUN; the beat is dropped and load_ready is 0.
- Simultaneous cwr and crd to the same bank and address: cdata_rd returns the old word (read-before-write).
- Data is stored unmodified; no arithmetic in this block.

## Timing
- Reset values:
  - ready=0, done=0, err=0, load_ready=0 for one cycle after reset release (state IDLE drives it 1 thereafter).
  - dump_valid=0, dump_data=0, state=IDLE, counters 0.
- Memory arrays have no reset; contents persist across reset.
- ready rises the cycle after the last load beat. It falls the cycle after busy is first sampled high.
- done rises the cycle after busy is sampled low in RUN (non-dump build).
- idata/cdata_rd have zero latency. A write is visible to a read the cycle after the write edge.
- Reset mid-operation aborts to IDLE immediately. ready, done and dump_valid drop asynchronously.

## Configuration
- CONV_HOST_DUMP_EN defined: DUMP state streams L1[0..1023] in order.
  - dump_valid=1 and dump_data=L1[dump_cnt] are registered.
  - The address advances on dump_valid & dump_ready.
  - After beat 1023 is accepted, the FSM goes to DONE.
  - done stays 0 during DUMP.
- Not defined: no DUMP state. dump_valid and dump_data are tied 0 and dump_ready is ignored; RUN→DONE directly.

## Test plan
- Load ramp (pixel k = k): after 4096 beats, ready=1 the next cycle. idata at iaddr=0x7FF reads 0x007FF. Load beats while in READY are refused and set err=1.
- Busy handshake: busy 0→1 → ready=0 the next cycle. busy 1→0 after 10 cycles → done=1 (non-dump build).
- Layer write/read in RUN:
  - cwr, csel=001, caddr_wr=0xFFF, data 0x12345 → next cycle crd at 0xFFF returns 0x12345.
  - csel=011, caddr_wr=0x01F → L1[31] written.
- Protocol errors: csel=011 write to 0x400 → err=1, L1 unchanged. cwr with csel=010 → ignored, err=1.
- Dump (CONV_HOST_DUMP_EN): L1[i] = i. With dump_ready toggling every other cycle, 1024 beats emerge with data 0..1023 in order, then done=1.
- Reset (low) asserted mid-LOAD at beat 2000: state IDLE and ready=0. A reload of 4096 beats then completes normally.

Source files
------------

// File: rtl/conv_mem_host.sv
// Memory-side responder for the CONV engine: image store, L0/L1 layer memories, load/ready/busy/done handshake.
// Optional L1 dump stream is enabled by defining CONV_HOST_DUMP_EN.
module conv_mem_host #(
    parameter int IMG_AW = 12,
    parameter int L1_AW  = 10,
    parameter int DW     = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DW-1:0]     load_data,
    output logic              load_ready,
    output logic              ready,
    input  logic              busy,
    input  logic [IMG_AW-1:0] iaddr,
    output logic [DW-1:0]     idata,
    input  logic              cwr,
    input  logic [IMG_AW-1:0] caddr_wr,
    input  logic [DW-1:0]     cdata_wr,
    input  logic              crd,
    input  logic [IMG_AW-1:0] caddr_rd,
    output logic [DW-1:0]     cdata_rd,
    input  logic [2:0]        csel,
    output logic              done,
    output logic              err,
    output logic              dump_valid,
    output logic [DW-1:0]     dump_data,
    input  logic              dump_ready
);
    localparam logic [2:0] SEL_L0 = 3'b001;
    localparam logic [2:0] SEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        IDLE, LOAD, READY, RUN,
`ifdef CONV_HOST_DUMP_EN
        DUMP,
`endif
        DONE
    } state_t;

    state_t            state;
    logic [IMG_AW-1:0] cnt;
    logic [DW-1:0]     img [1 << IMG_AW];
    logic [DW-1:0]     l0  [1 << IMG_AW];
    logic [DW-1:0]     l1  [1 << L1_AW];

    logic accept, wr_l0, wr_l1, rd_l0, rd_l1, wr_l1_oob, rd_l1_oob, proto_err;

    assign accept    = load_valid & load_ready;
    assign wr_l0     = cwr & (csel == SEL_L0);
    assign wr_l1     = cwr & (csel == SEL_L1);
    assign rd_l0     = crd & (csel == SEL_L0);
    assign rd_l1     = crd & (csel == SEL_L1);
    assign wr_l1_oob = wr_l1 & (|caddr_wr[IMG_AW-1:L1_AW]);
    assign rd_l1_oob = rd_l1 & (|caddr_rd[IMG_AW-1:L1_AW]);
    assign proto_err = ((cwr | crd) & (state != RUN)) | wr_l1_oob | rd_l1_oob
                     | (cwr & ~wr_l0 & ~wr_l1)
                     | (load_valid & ((state == READY) | (state == RUN)));

    assign idata = img[iaddr];

    always_comb begin
        cdata_rd = '0;
        if (rd_l0)
            cdata_rd = l0[caddr_rd];
        else if (rd_l1)
            cdata_rd = l1[caddr_rd[L1_AW-1:0]];
    end

    // Arrays carry no reset so their contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept)
            img[cnt] <= load_data;
        if (wr_l0)
            l0[caddr_wr] <= cdata_wr;
        if (wr_l1 && !wr_l1_oob)
            l1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
    end

`ifdef CONV_HOST_DUMP_EN
    logic [L1_AW-1:0] dump_cnt;
    logic [L1_AW-1:0] dump_nxt;
    assign dump_nxt = dump_cnt + 1'b1;
`else
    logic unused_dump_ready;
    assign unused_dump_ready = dump_ready;
    assign dump_valid = 1'b0;
    assign dump_data  = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            load_ready <= 1'b0;
            ready      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef CONV_HOST_DUMP_EN
            dump_cnt   <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
`endif
        end else begin
            if (proto_err)
                err <= 1'b1;
            if (accept)
                cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    load_ready <= 1'b1;
                    if (accept)
                        state <= LOAD;
                end
                LOAD: begin
                    if (accept && cnt == '1) begin
                        state      <= READY;
                        load_ready <= 1'b0;
                        ready      <= 1'b1;
                    end
                end
                READY: begin
                    if (busy) begin
                        state <= RUN;
                        ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (!busy) begin
`ifdef CONV_HOST_DUMP_EN
                        state      <= DUMP;
                        dump_cnt   <= '0;
                        dump_valid <= 1'b1;
                        dump_data  <= l1[0];
`else
                        state      <= DONE;
                        done       <= 1'b1;
                        load_ready <= 1'b1;
`endif
                    end
                end
`ifdef CONV_HOST_DUMP_EN
                DUMP: begin
                    if (dump_valid && dump_ready) begin
                        if (dump_cnt == '1) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            done       <= 1'b1;
                            load_ready <= 1'b1;
                        end else begin
                            dump_cnt  <= dump_nxt;
                            dump_data <= l1[dump_nxt];
                        end
                    end
                end
`endif
                DONE: begin
                    // cnt wrapped to 0 at the end of the previous load, so this beat lands in img[0].
                    if (accept) begin
                        state <= LOAD;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mem_host.sv
// Directed/randomized bench for conv_mem_host with an array-based reference model.
// Dump stream checks compile in when CONV_HOST_DUMP_EN is defined.
module tb_conv_mem_host;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [19:0] load_data;
    logic        load_ready;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        done;
    logic        err;
    logic        dump_valid;
    logic [19:0] dump_data;
    logic        dump_ready;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [19:0] img_m [4096];
    logic [19:0] l0_m  [4096];
    logic [19:0] l1_m  [1024];

    always #5 clk = ~clk;

    conv_mem_host #(.IMG_AW(12), .L1_AW(10), .DW(20)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .done(done), .err(err),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n beats into the host, honouring load_ready; model address follows accepted beats.
    task automatic load_image(input int n, input bit ramp);
        int acc = 0;
        int budget = n + 100;
        logic [19:0] d;
        while (acc < n && budget > 0) begin
            d = ramp ? 20'(acc) : 20'($urandom);
            load_valid = 1'b1;
            load_data  = d;
            if (load_ready) begin
                img_m[acc] = d;
                acc++;
            end
            tick();
            budget--;
        end
        load_valid = 1'b0;
        chk("load_beats", acc, n);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] sel, input logic [11:0] a, input logic [19:0] exp);
        crd = 1'b1; csel = sel; caddr_rd = a;
        #1;
        chk(tag, cdata_rd, exp);
    endtask

    initial begin
        logic [11:0] a;
        logic [19:0] d;
        reset = 1'b0; load_valid = 1'b0; load_data = '0; busy = 1'b0; iaddr = '0;
        cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
        csel = '0; dump_ready = 1'b0;
        tick(); tick();
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_data", dump_data, 0);
        reset = 1'b1;
        chk("lr_after_release", load_ready, 0);
        tick();
        chk("lr_idle", load_ready, 1);

        // Reset in the middle of a load
        load_image(2000, 1'b0);
        chk("ready_midload", ready, 0);
        chk("lr_midload", load_ready, 1);
        reset = 1'b0;
        #1;
        chk("async_ready", ready, 0);
        chk("async_load_ready", load_ready, 0);
        tick();
        reset = 1'b1;
        tick();
        iaddr = 12'd5;
        #1;
        chk("img_persist", idata, img_m[5]);

        // Full ramp load
        load_image(4096, 1'b1);
        chk("ready_rise", ready, 1);
        chk("lr_ready", load_ready, 0);
        chk("err_after_load", err, 0);
        iaddr = 12'h7FF;
        #1;
        chk("idata_7ff", idata, 20'h007FF);
        for (int i = 0; i < 8; i++) begin
            a = 12'($urandom);
            iaddr = a;
            #1;
            chk("idata_rand", idata, img_m[a]);
        end

        // Busy handshake and layer traffic
        busy = 1'b1;
        tick();
        chk("ready_fall", ready, 0);
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'hFFF; cdata_wr = 20'h12345;
        l0_m[12'hFFF] = 20'h12345;
        tick();
        cwr = 1'b0;
        rd_chk("l0_fff", 3'b001, 12'hFFF, 20'h12345);
        crd = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            cwr = 1'b1; csel = 3'b011; caddr_wr = 12'(i); cdata_wr = 20'(i);
            l1_m[i] = 20'(i);
            tick();
        end
        for (int i = 0; i < 64; i++) begin
            a = 12'($urandom); d = 20'($urandom);
            cwr = 1'b1; csel = 3'b001; caddr_wr = a; cdata_wr = d;
            l0_m[a] = d;
            tick();
        end
        cwr = 1'b0;
        rd_chk("l1_31", 3'b011, 12'h01F, l1_m[31]);
        // Same-address write and read in one cycle
        a = 12'h123; d = 20'($urandom);
        cwr = 1'b1; caddr_wr = a; cdata_wr = d;
        rd_chk("rbw_old", 3'b001, a, l0_m[a]);
        tick();
        l0_m[a] = d;
        cwr = 1'b0;
        rd_chk("rbw_new", 3'b001, a, d);
        for (int i = 0; i < 20; i++) begin
            a = 12'($urandom);
            rd_chk("l0_rand", 3'b001, a, l0_m[a]);
            a = 12'($urandom_range(0, 1023));
            rd_chk("l1_rand", 3'b011, a, l1_m[a]);
        end
        crd = 1'b0;
        #1;
        chk("rd_idle_zero", cdata_rd, 0);
        rd_chk("rd_nosel_zero", 3'b000, 12'h010, 20'h0);
        crd = 1'b0;
        tick();
        chk("err_clean_run", err, 0);
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h400; cdata_wr = 20'hFFFFF;
        tick();
        cwr = 1'b0;
        chk("err_l1_oob", err, 1);
        rd_chk("l1_oob_nowrite", 3'b011, 12'h000, l1_m[0]);
        crd = 1'b0;

        busy = 1'b0;
        tick();
`ifdef CONV_HOST_DUMP_EN
        begin
            int beats = 0;
            int budget = 5000;
            bit rdy = 1'b0;
            chk("dump_valid_rise", dump_valid, 1);
            while (beats < 1024 && budget > 0) begin
                rdy = ~rdy;
                dump_ready = rdy;
                if (dump_valid && rdy) begin
                    chk("dump_data", dump_data, l1_m[beats]);
                    chk("done_in_dump", done, 0);
                    beats++;
                end
                tick();
                budget--;
            end
            dump_ready = 1'b0;
            chk("dump_beats", beats, 1024);
            chk("dump_valid_fall", dump_valid, 0);
        end
`endif
        chk("done_rise", done, 1);
        chk("lr_done", load_ready, 1);

        // Restart from DONE
        d = 20'($urandom);
        load_valid = 1'b1; load_data = d;
        tick();
        load_valid = 1'b0;
        img_m[0] = d;
        iaddr = '0;
        #1;
        chk("restart_img0", idata, d);
        chk("done_fall", done, 0);
        reset = 1'b0;
        #1;
        chk("err_reset_clear", err, 0);
        tick();
        reset = 1'b1;
        tick();

        // Unmapped bank select
        load_image(4096, 1'b0);
        busy = 1'b1;
        tick();
        cwr = 1'b1; csel = 3'b010; caddr_wr = 12'h010; cdata_wr = 20'h55555;
        tick();
        cwr = 1'b0;
        chk("err_badsel", err, 1);
        rd_chk("badsel_l0", 3'b001, 12'h010, l0_m[12'h010]);
        rd_chk("badsel_l1", 3'b011, 12'h010, l1_m[12'h010]);
        crd = 1'b0;
        busy = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Load beat offered while READY
        load_image(4096, 1'b0);
        chk("ready_rise2", ready, 1);
        chk("err_clean2", err, 0);
        load_valid = 1'b1; load_data = 20'hABCDE;
        tick();
        load_valid = 1'b0;
        chk("err_ready_load", err, 1);
        chk("ready_hold", ready, 1);
        chk("lr_ready_refuse", load_ready, 0);
        iaddr = '0;
        #1;
        chk("ready_beat_dropped", idata, img_m[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
